// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide scheduler: MD classes, unit opcodes, FSM states.
package md_pkg;

    localparam int CNT_W = 5;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_cls_e;

    typedef enum logic [2:0] {
        OP_MULTU = 3'b000,
        OP_MULT  = 3'b001,
        OP_DIVU  = 3'b010,
        OP_DIV   = 3'b011
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_scheduler_if.sv
// Pipeline/MD-unit/hazard-unit signals of the MD scheduler; slave is the scheduler side.
interface md_scheduler_if;
    import md_pkg::*;

    logic       e_valid;
    md_cls_e    e_mdcls;
    logic       d_md_use;
    logic       flush;
    logic       md_start;
    logic [2:0] md_op;
    logic       hi_write;
    logic       lo_write;
    logic       commit;
    logic       busy;
    logic       stall_d;
    logic       err;

    modport master (
        output e_valid, e_mdcls, d_md_use, flush,
        input  md_start, md_op, hi_write, lo_write, commit, busy, stall_d, err
    );

    modport slave (
        input  e_valid, e_mdcls, d_md_use, flush,
        output md_start, md_op, hi_write, lo_write, commit, busy, stall_d, err
    );

endinterface

// File: rtl/md_lat_counter.sv
// Operation latency counter: loads the MUL/DIV latency, counts down, flags the final busy cycle.
module md_lat_counter
    import md_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             is_div,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    localparam logic [CNT_W-1:0] MUL_L = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_L = CNT_W'(DIV_LAT);

    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (load)
            cnt <= is_div ? DIV_L : MUL_L;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/md_scheduler.sv
// MD unit sequencing: start/opcode decode, HI/LO strobes, latency tracking, commit and D-stall.
// Optional MD_CANCEL_EN: a flush during RUN aborts the in-flight operation without commit.
module md_scheduler
    import md_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic           clk,
    input  logic           reset,
    md_scheduler_if.slave  bus
);

    md_state_e        state;
    logic             err_q;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             live, run, is_mul, is_div, cancel, viol;

    assign live   = bus.e_valid & ~bus.flush;
    assign run    = (state == ST_RUN);
    assign is_mul = (bus.e_mdcls == MD_MULT) | (bus.e_mdcls == MD_MULTU);
    assign is_div = (bus.e_mdcls == MD_DIV)  | (bus.e_mdcls == MD_DIVU);
    assign viol   = run & live & (bus.e_mdcls != MD_NONE) &
                    (bus.e_mdcls != MD_MFHI) & (bus.e_mdcls != MD_MFLO);

`ifdef MD_CANCEL_EN
    assign cancel = run & bus.flush;
`else
    assign cancel = 1'b0;
`endif

    // Every output is forced low in a reset cycle, even ones derived from stale state.
    always_comb begin
        bus.md_start = ~reset & ~run & live & (is_mul | is_div);
        bus.hi_write = ~reset & ~run & live & (bus.e_mdcls == MD_MTHI);
        bus.lo_write = ~reset & ~run & live & (bus.e_mdcls == MD_MTLO);
        bus.md_op    = 3'b000;
        if (bus.md_start) begin
            case (bus.e_mdcls)
                MD_MULT:  bus.md_op = OP_MULT;
                MD_DIVU:  bus.md_op = OP_DIVU;
                MD_DIV:   bus.md_op = OP_DIV;
                default:  bus.md_op = OP_MULTU;
            endcase
        end
        bus.commit  = ~reset & run & last & ~cancel;
        bus.busy    = ~reset & run;
        bus.stall_d = ~reset & bus.d_md_use & (run | bus.md_start);
        bus.err     = ~reset & err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            err_q <= 1'b0;
        end else begin
            if (viol)
                err_q <= 1'b1;
            case (state)
                ST_IDLE: if (bus.md_start) state <= ST_RUN;
                ST_RUN:  if (cancel || last) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    md_lat_counter #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .load   (bus.md_start),
        .is_div (is_div),
        .clear  (cancel),
        .cnt    (cnt),
        .last   (last)
    );

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: commit cycles tracked by a scoreboard, strobes/stall checked inline.
module tb_md_scheduler;
    import md_pkg::*;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   sb[$];

    md_scheduler_if mif();

    md_scheduler #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (mif.slave)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drv(input logic v, input md_cls_e c, input logic f, input logic d);
        mif.e_valid  = v;
        mif.e_mdcls  = c;
        mif.flush    = f;
        mif.d_md_use = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every commit must match the oldest expected commit cycle.
    always @(negedge clk) begin
        if (mif.commit === 1'b1) begin
            if (sb.size() == 0)
                chk("commit_unexpected", 1, 0);
            else
                chk("commit_cycle", cyc, sb.pop_front());
        end
    end

    initial begin
        rst = 1'b1;
        drv(0, MD_NONE, 0, 0);
        tick();
        tick();

        // reset cycle: live MULT must not start, everything low
        drv(1, MD_MULT, 0, 1);
        #1;
        chk("rst_start", mif.md_start, 0);
        chk("rst_busy", mif.busy, 0);
        chk("rst_stall", mif.stall_d, 0);
        chk("rst_commit", mif.commit, 0);
        chk("rst_err", mif.err, 0);
        tick();
        rst = 1'b0;

        // MULT latency and commit
        drv(1, MD_MULT, 0, 0);
        #1;
        chk("mul_start", mif.md_start, 1);
        chk("mul_op", mif.md_op, 3'b001);
        sb.push_back(cyc + MUL_LAT);
        tick();
        drv(0, MD_NONE, 0, 0);
        for (int k = 1; k <= MUL_LAT; k++) begin
            #1;
            chk("mul_busy", mif.busy, 1);
            chk("mul_commit", mif.commit, (k == MUL_LAT));
            tick();
        end
        #1;
        chk("mul_idle", mif.busy, 0);

        // back-to-back MULTU right after commit
        drv(1, MD_MULTU, 0, 0);
        #1;
        chk("b2b_start", mif.md_start, 1);
        chk("b2b_op", mif.md_op, 3'b000);
        sb.push_back(cyc + MUL_LAT);
        tick();
        drv(0, MD_NONE, 0, 0);
        repeat (MUL_LAT) tick();

        // DIVU with D-stage MD instruction held
        drv(1, MD_DIVU, 0, 1);
        #1;
        chk("divu_op", mif.md_op, 3'b010);
        chk("divu_stall0", mif.stall_d, 1);
        sb.push_back(cyc + DIV_LAT);
        tick();
        drv(0, MD_NONE, 0, 1);
        for (int k = 1; k <= DIV_LAT; k++) begin
            #1;
            chk("divu_stall", mif.stall_d, 1);
            tick();
        end
        #1;
        chk("divu_stall_end", mif.stall_d, 0);
        chk("divu_idle", mif.busy, 0);

        // HI/LO moves and flush suppression
        drv(1, MD_MTLO, 0, 0);
        #1;
        chk("mtlo_lo", mif.lo_write, 1);
        chk("mtlo_hi", mif.hi_write, 0);
        chk("mtlo_start", mif.md_start, 0);
        tick();
        drv(0, MD_NONE, 0, 0);
        #1;
        chk("mtlo_once", mif.lo_write, 0);
        chk("mtlo_busy", mif.busy, 0);
        drv(1, MD_MTLO, 1, 0);
        #1;
        chk("mtlo_flush", mif.lo_write, 0);
        drv(1, MD_MTHI, 0, 0);
        #1;
        chk("mthi_hi", mif.hi_write, 1);
        drv(1, MD_MFHI, 0, 1);
        #1;
        chk("mfhi_strobe", {mif.hi_write, mif.lo_write, mif.md_start}, 0);
        chk("mfhi_stall", mif.stall_d, 0);
        drv(1, MD_MULT, 1, 0);
        #1;
        chk("flush_start", mif.md_start, 0);
        tick();
        drv(0, MD_NONE, 0, 0);
        #1;
        chk("flush_nobusy", mif.busy, 0);

        // protocol violation during RUN
        drv(1, MD_MULT, 0, 0);
        #1;
        sb.push_back(cyc + MUL_LAT);
        tick();
        drv(1, MD_MULTU, 0, 0);
        #1;
        chk("viol_start", mif.md_start, 0);
        chk("nonmd_stall", mif.stall_d, 0);
        tick();
        drv(0, MD_NONE, 0, 0);
        #1;
        chk("viol_err", mif.err, 1);
        repeat (MUL_LAT) tick();
        #1;
        chk("viol_sticky", mif.err, 1);
        rst = 1'b1;
        #1;
        chk("viol_rst_now", mif.err, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("viol_cleared", mif.err, 0);

        // flush during a DIV at T+4
        drv(1, MD_DIV, 0, 0);
        #1;
        chk("div_op", mif.md_op, 3'b011);
`ifndef MD_CANCEL_EN
        sb.push_back(cyc + DIV_LAT);
`endif
        tick();
        drv(0, MD_NONE, 0, 0);
        repeat (3) tick();
        drv(0, MD_NONE, 1, 0);
        tick();
        drv(0, MD_NONE, 0, 0);
        #1;
`ifdef MD_CANCEL_EN
        chk("cancel_busy", mif.busy, 0);
`else
        chk("nocancel_busy", mif.busy, 1);
`endif
        repeat (DIV_LAT) tick();

        // flush in the same cycle as the final count
        drv(1, MD_MULT, 0, 0);
        #1;
`ifndef MD_CANCEL_EN
        sb.push_back(cyc + MUL_LAT);
`endif
        tick();
        drv(0, MD_NONE, 0, 0);
        repeat (MUL_LAT - 1) tick();
        drv(0, MD_NONE, 1, 0);
        #1;
`ifdef MD_CANCEL_EN
        chk("cancel_last_commit", mif.commit, 0);
`else
        chk("flush_last_commit", mif.commit, 1);
`endif
        tick();
        drv(0, MD_NONE, 0, 0);
        #1;
        chk("last_idle", mif.busy, 0);
        tick();

        // reset at T+3 of a MULT, restart at T+4
        drv(1, MD_MULT, 0, 0);
        tick();
        drv(0, MD_NONE, 0, 0);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        chk("midrst_busy", mif.busy, 0);
        chk("midrst_commit", mif.commit, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("postrst_busy", mif.busy, 0);
        drv(1, MD_MULT, 0, 0);
        #1;
        chk("postrst_start", mif.md_start, 1);
        sb.push_back(cyc + MUL_LAT);
        tick();
        drv(0, MD_NONE, 0, 0);
        repeat (MUL_LAT + 1) tick();

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
